// File: rtl/framebuf_pkg.sv
// Shared types and constants for the frame-buffer read path.
package framebuf_pkg;

   localparam int unsigned PIX_W_DEF = 12;
   localparam int unsigned H_RES_DEF = 320;
   localparam int unsigned V_RES_DEF = 240;
   localparam int unsigned NUM_BARS  = 8;

   typedef logic [11:0] pixel_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pix_flags_t;

   localparam int unsigned FLAGS_W = $bits(pix_flags_t);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // Vertical colour bars, left to right, in RGB444.
   localparam pixel_t BAR_COLOURS [NUM_BARS] = '{
      12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
      12'hF0F, 12'hF00, 12'h00F, 12'h000
   };

endpackage

// File: rtl/framebuf_skid_fifo.sv
// Two-entry skid FIFO with synchronous flush; push and pop may share a cycle.
module framebuf_skid_fifo #(
   parameter int unsigned W = 15
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count,
   output logic         o_empty
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push_c, do_pop_c;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_pop_c  = i_pop && (count_q != 2'd0);
      do_push_c = i_push && ((count_q != 2'd2) || do_pop_c);
      if (i_flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push_c) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(do_push_c) - 2'(do_pop_c);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;
   assign o_empty = (count_q == 2'd0);

endmodule

// File: rtl/framebuf_reader.sv
// Raster-order frame-buffer reader producing a valid/ready pixel stream.
// Optional colour-bar test pattern is built when FRAMEBUF_TEST_PATTERN_EN is defined.
module framebuf_reader
   import framebuf_pkg::*;
#(
   parameter int unsigned PIX_W  = PIX_W_DEF,
   parameter int unsigned H_RES  = H_RES_DEF,
   parameter int unsigned V_RES  = V_RES_DEF,
   parameter int unsigned ADDR_W = $clog2(H_RES * V_RES)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_frame_start,
   input  logic              i_pattern_sel,
   output logic              o_bram_rd,
   output logic [ADDR_W-1:0] o_bram_rd_addr,
   input  logic [PIX_W-1:0]  i_bram_data,
   output logic [PIX_W-1:0]  o_pix_data,
   output logic              o_pix_valid,
   input  logic              i_pix_ready,
   output logic              o_pix_sof,
   output logic              o_pix_eol,
   output logic              o_pix_eof,
   output logic              o_busy
);

   localparam int unsigned NUM_PIX = H_RES * V_RES;
   localparam int unsigned XW      = $clog2(H_RES);
   localparam int unsigned YW      = $clog2(V_RES);
   localparam int unsigned FIFO_W  = PIX_W + FLAGS_W;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic              inflight_q, inflight_d;
   pix_flags_t        infl_flags_q, infl_flags_d;

   logic              pop_c, issue_c, last_addr_c;
   logic [2:0]        occ_c;
   pix_flags_t        issue_flags_c, head_flags_c;
   logic [PIX_W-1:0]  push_pix_c;
   logic [FIFO_W-1:0] fifo_rd_data;
   logic [1:0]        fifo_count;
   logic              fifo_empty;

`ifdef FRAMEBUF_TEST_PATTERN_EN
   localparam int unsigned BAR_W = H_RES / NUM_BARS;
   logic              pattern_q, pattern_d;
   logic [PIX_W-1:0]  infl_pix_q, infl_pix_d;
   logic [2:0]        bar_idx_c;
`else
   logic              unused_pattern_sel_c;
   assign unused_pattern_sel_c = i_pattern_sel;
`endif

   // Credit rule: in-flight reads plus buffered pixels never exceed the FIFO depth.
   always_comb begin
      pop_c         = !fifo_empty && i_pix_ready;
      occ_c         = 3'(inflight_q) + 3'(fifo_count) - 3'(pop_c);
      issue_c       = (state_q == RUN) && (occ_c < 3'd2);
      last_addr_c   = (addr_q == ADDR_W'(NUM_PIX - 1));
      issue_flags_c.sof = (x_q == '0) && (y_q == '0);
      issue_flags_c.eol = (x_q == XW'(H_RES - 1));
      issue_flags_c.eof = last_addr_c;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      x_d          = x_q;
      y_d          = y_q;
      inflight_d   = issue_c;
      infl_flags_d = issue_c ? issue_flags_c : infl_flags_q;
`ifdef FRAMEBUF_TEST_PATTERN_EN
      pattern_d    = pattern_q;
      bar_idx_c    = 3'(32'(x_q) / BAR_W);
      infl_pix_d   = issue_c ? PIX_W'(BAR_COLOURS[bar_idx_c]) : infl_pix_q;
`endif
      case (state_q)
         RUN: begin
            if (issue_c) begin
               if (last_addr_c) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (x_q == XW'(H_RES - 1)) begin
                     x_d = '0;
                     y_d = y_q + YW'(1);
                  end else begin
                     x_d = x_q + XW'(1);
                  end
               end
            end
         end
         DRAIN: begin
            // The last pixel leaving this cycle is enough to call the frame done.
            if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop_c))) begin
               state_d = IDLE;
            end
         end
         default: ;
      endcase
      // Start or restart: any in-flight return and buffered pixels belong to the old frame.
      if (i_frame_start) begin
         state_d    = RUN;
         addr_d     = '0;
         x_d        = '0;
         y_d        = '0;
         inflight_d = 1'b0;
`ifdef FRAMEBUF_TEST_PATTERN_EN
         pattern_d  = i_pattern_sel;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         inflight_q   <= 1'b0;
         infl_flags_q <= '0;
`ifdef FRAMEBUF_TEST_PATTERN_EN
         pattern_q    <= 1'b0;
         infl_pix_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         x_q          <= x_d;
         y_q          <= y_d;
         inflight_q   <= inflight_d;
         infl_flags_q <= infl_flags_d;
`ifdef FRAMEBUF_TEST_PATTERN_EN
         pattern_q    <= pattern_d;
         infl_pix_q   <= infl_pix_d;
`endif
      end
   end

`ifdef FRAMEBUF_TEST_PATTERN_EN
   assign push_pix_c = pattern_q ? infl_pix_q : i_bram_data;
   assign o_bram_rd  = issue_c && !pattern_q;
`else
   assign push_pix_c = i_bram_data;
   assign o_bram_rd  = issue_c;
`endif

   framebuf_skid_fifo #(
      .W (FIFO_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_frame_start),
      .i_push  (inflight_q),
      .i_data  ({push_pix_c, infl_flags_q}),
      .i_pop   (pop_c),
      .o_data  (fifo_rd_data),
      .o_count (fifo_count),
      .o_empty (fifo_empty)
   );

   assign head_flags_c   = pix_flags_t'(fifo_rd_data[FLAGS_W-1:0]);
   assign o_bram_rd_addr = addr_q;
   assign o_pix_valid    = !fifo_empty;
   assign o_pix_data     = fifo_rd_data[FIFO_W-1:FLAGS_W];
   assign o_pix_sof      = o_pix_valid && head_flags_c.sof;
   assign o_pix_eol      = o_pix_valid && head_flags_c.eol;
   assign o_pix_eof      = o_pix_valid && head_flags_c.eof;
   assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_framebuf_reader.sv
// Scoreboard bench for framebuf_reader on a reduced 32x8 frame.
module tb_framebuf_reader;

   localparam int unsigned PIX_W  = 12;
   localparam int unsigned H_RES  = 32;
   localparam int unsigned V_RES  = 8;
   localparam int unsigned N_PIX  = H_RES * V_RES;
   localparam int unsigned ADDR_W = $clog2(N_PIX);

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_frame_start = 1'b0;
   logic              i_pattern_sel = 1'b0;
   logic              o_bram_rd;
   logic [ADDR_W-1:0] o_bram_rd_addr;
   logic [PIX_W-1:0]  i_bram_data = '0;
   logic [PIX_W-1:0]  o_pix_data;
   logic              o_pix_valid;
   logic              i_pix_ready = 1'b0;
   logic              o_pix_sof, o_pix_eol, o_pix_eof, o_busy;

   framebuf_reader #(
      .PIX_W (PIX_W), .H_RES (H_RES), .V_RES (V_RES), .ADDR_W (ADDR_W)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_frame_start  (i_frame_start),
      .i_pattern_sel  (i_pattern_sel),
      .o_bram_rd      (o_bram_rd),
      .o_bram_rd_addr (o_bram_rd_addr),
      .i_bram_data    (i_bram_data),
      .o_pix_data     (o_pix_data),
      .o_pix_valid    (o_pix_valid),
      .i_pix_ready    (i_pix_ready),
      .o_pix_sof      (o_pix_sof),
      .o_pix_eol      (o_pix_eol),
      .o_pix_eof      (o_pix_eof),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // BRAM model: mem[a] = a[11:0], one-cycle read latency.
   always @(posedge i_clk) begin
      if (o_bram_rd) i_bram_data <= 12'(o_bram_rd_addr);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

   int          checks = 0;
   int          errors = 0;
   logic [14:0] exp_q [$];
   int          rd_cnt = 0;
   int          pop_cnt = 0;
   int          cyc = 0;
   int          eof_cyc = -1;
   bit          pattern_mode = 0;
   logic        prev_stall = 1'b0;
   logic [14:0] prev_head = '0;

   task automatic fill_expected();
      exp_q.delete();
      for (int a = 0; a < int'(N_PIX); a++) begin
         int x;
         logic [11:0] d;
         x = a % int'(H_RES);
         d = pattern_mode ? bars[x / (int'(H_RES) / 8)] : 12'(a);
         exp_q.push_back({d, 1'(a == 0), 1'(x == int'(H_RES) - 1), 1'(a == int'(N_PIX) - 1)});
      end
   endtask

   task automatic monitor();
      logic [14:0] got;
      logic [14:0] exp;
      logic pop_now;
      got     = {o_pix_data, o_pix_sof, o_pix_eol, o_pix_eof};
      pop_now = o_pix_valid && i_pix_ready;
      if (prev_stall) begin
         checks++;
         if (!o_pix_valid || got !== prev_head) begin
            errors++;
            $display("FAIL stall_hold got v=%0b %h exp v=1 %h", o_pix_valid, got, prev_head);
         end
      end
      if (pattern_mode) begin
         checks++;
         if (o_bram_rd !== 1'b0) begin
            errors++;
            $display("FAIL pattern_no_read got rd=%0b exp 0", o_bram_rd);
         end
      end else if (o_bram_rd) begin
         checks++;
         if (o_bram_rd_addr !== ADDR_W'(rd_cnt)) begin
            errors++;
            $display("FAIL rd_addr got %0d exp %0d", o_bram_rd_addr, rd_cnt);
         end
      end
      checks++;
      if (rd_cnt + (o_bram_rd ? 1 : 0) - pop_cnt - (pop_now ? 1 : 0) > 2) begin
         errors++;
         $display("FAIL occupancy got %0d exp <=2",
                  rd_cnt + (o_bram_rd ? 1 : 0) - pop_cnt - (pop_now ? 1 : 0));
      end
      if (pop_now) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pixel got %h exp none", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL pixel got %h exp %h (data,sof,eol,eof)", got, exp);
            end
         end
         if (o_pix_eof) eof_cyc = cyc;
      end
      prev_stall = o_pix_valid && !i_pix_ready;
      prev_head  = got;
      rd_cnt     = rd_cnt + (o_bram_rd ? 1 : 0);
      pop_cnt    = pop_cnt + (pop_now ? 1 : 0);
   endtask

   // One clock: drive inputs, sample just after, advance to the next falling edge.
   task automatic clk_cycle(input logic rdy, input logic start, input logic rst);
      i_pix_ready   = rdy;
      i_frame_start = start;
      i_rst         = rst;
      cyc           = start ? 0 : cyc + 1;
      #1;
      monitor();
      if (rst) begin
         exp_q.delete();
         rd_cnt = 0; pop_cnt = 0; prev_stall = 1'b0;
      end else if (start) begin
         fill_expected();
         rd_cnt = 0; pop_cnt = 0; prev_stall = 1'b0;
      end
      @(negedge i_clk);
      i_frame_start = 1'b0;
      i_rst         = 1'b0;
   endtask

   task automatic run_drain(input bit rand_rdy, input int budget, input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         clk_cycle(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got %0d pending exp 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      logic [ADDR_W+PIX_W+5:0] outs;
      @(negedge i_clk);
      clk_cycle(1'b0, 1'b0, 1'b1);
      clk_cycle(1'b0, 1'b0, 1'b1);
      clk_cycle(1'b0, 1'b1, 1'b1);
      #1;
      outs = {o_bram_rd, o_bram_rd_addr, o_pix_data, o_pix_valid, o_pix_sof, o_pix_eol, o_pix_eof, o_busy};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", outs);
      end
      clk_cycle(1'b0, 1'b0, 1'b0);
      clk_cycle(1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_bram_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_wins_start got busy=%0b rd=%0b exp 0 0", o_busy, o_bram_rd);
      end
   endtask

   task automatic test_full_frame();
      pattern_mode = 0;
      eof_cyc = -1;
      clk_cycle(1'b1, 1'b1, 1'b0);
      i_pix_ready = 1'b1;
      #1;
      checks++;
      if (o_bram_rd !== 1'b1 || o_bram_rd_addr !== '0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL first_read got rd=%0b addr=%0d busy=%0b exp 1 0 1", o_bram_rd, o_bram_rd_addr, o_busy);
      end
      clk_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (o_pix_valid !== 1'b0) begin
         errors++;
         $display("FAIL early_valid got %0b exp 0", o_pix_valid);
      end
      clk_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (o_pix_valid !== 1'b1 || o_pix_sof !== 1'b1 || o_pix_data !== 12'h000) begin
         errors++;
         $display("FAIL first_pixel got v=%0b sof=%0b d=%h exp 1 1 000", o_pix_valid, o_pix_sof, o_pix_data);
      end
      run_drain(1'b0, N_PIX + 20, "full");
      checks++;
      if (eof_cyc != int'(N_PIX) + 2) begin
         errors++;
         $display("FAIL eof_cycle got %0d exp %0d", eof_cyc, N_PIX + 2);
      end
      clk_cycle(1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_frame got %0b exp 0", o_busy);
      end
   endtask

   task automatic test_random_ready();
      pattern_mode = 0;
      clk_cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      run_drain(1'b1, 8 * N_PIX, "random");
   endtask

   task automatic test_stall();
      int n = 0;
      pattern_mode = 0;
      clk_cycle(1'b0, 1'b1, 1'b0);
      while (!o_pix_valid && n < 10) begin
         clk_cycle(1'b0, 1'b0, 1'b0);
         n++;
      end
      for (int i = 0; i < 100; i++) clk_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (rd_cnt != 2 || o_pix_valid !== 1'b1 || o_pix_data !== 12'h000) begin
         errors++;
         $display("FAIL stall_reads got rd=%0d v=%0b d=%h exp 2 1 000", rd_cnt, o_pix_valid, o_pix_data);
      end
      run_drain(1'b0, N_PIX + 20, "stall");
   endtask

   task automatic test_restart();
      int n = 0;
      pattern_mode = 0;
      clk_cycle(1'b1, 1'b1, 1'b0);
      while (pop_cnt < 100 && n < 200) begin
         clk_cycle(1'b1, 1'b0, 1'b0);
         n++;
      end
      for (int i = 0; i < 4; i++) clk_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (rd_cnt - pop_cnt != 2 || o_pix_data !== 12'd100) begin
         errors++;
         $display("FAIL restart_full got outstanding=%0d d=%0d exp 2 100", rd_cnt - pop_cnt, o_pix_data);
      end
      clk_cycle(1'b0, 1'b1, 1'b0);
      run_drain(1'b0, N_PIX + 20, "restart");
   endtask

   task automatic test_reset_mid();
      logic [ADDR_W+PIX_W+5:0] outs;
      pattern_mode = 0;
      clk_cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) clk_cycle(1'b1, 1'b0, 1'b0);
      clk_cycle(1'b1, 1'b0, 1'b1);
      i_pix_ready = 1'b1;
      #1;
      outs = {o_bram_rd, o_bram_rd_addr, o_pix_data, o_pix_valid, o_pix_sof, o_pix_eol, o_pix_eof, o_busy};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got %h exp 0", outs);
      end
      for (int i = 0; i < 20; i++) clk_cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (rd_cnt != 0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle got rd=%0d busy=%0b exp 0 0", rd_cnt, o_busy);
      end
   endtask

`ifdef FRAMEBUF_TEST_PATTERN_EN
   task automatic test_pattern();
      pattern_mode  = 1;
      i_pattern_sel = 1'b1;
      clk_cycle(1'b1, 1'b1, 1'b0);
      i_pattern_sel = 1'b0;
      run_drain(1'b0, N_PIX + 20, "pattern");
      pattern_mode = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_random_ready();
      test_stall();
      test_restart();
      test_reset_mid();
`ifdef FRAMEBUF_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/framebuf_reader.md
Name: framebuf_reader

Overview:
- Read-side controller for the dual-clock camera frame buffer BRAM; runs entirely in the display/read clock domain.
- Generates raster-order BRAM read requests and absorbs the BRAM's 1-cycle read latency.
- Delivers pixels as a valid/ready stream with frame and line markers to the display pipeline.
- Uses a 2-entry skid FIFO so downstream backpressure never loses or duplicates a pixel.

Parameters:
- PIX_W, 12, pixel width (RGB444)
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- ADDR_W, $clog2(H_RES*V_RES) (17), BRAM address width

Ports:
- i_clk  in  1  read-domain clock; same clock as the BRAM read port
- i_rst  in  1  synchronous, active-high reset
- i_frame_start  in  1  single-cycle pulse; begin (or restart) a frame at address 0
- i_pattern_sel  in  1  select test pattern instead of BRAM data (see Optional Feature)
- o_bram_rd  out  1  BRAM read enable
- o_bram_rd_addr  out  ADDR_W  BRAM read address
- i_bram_data  in  PIX_W  BRAM read data; valid the cycle after o_bram_rd
- o_pix_data  out  PIX_W  stream pixel
- o_pix_valid  out  1  stream valid
- i_pix_ready  in  1  stream ready
- o_pix_sof  out  1  first pixel of frame (x=0, y=0), qualified by valid
- o_pix_eol  out  1  last pixel of line (x=H_RES-1), qualified by valid
- o_pix_eof  out  1  last pixel of frame, qualified by valid
- o_busy  out  1  high from the accepted i_frame_start until the last pixel is handshaken

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; state IDLE.
- States:
  - IDLE: i_frame_start -> RUN.
  - RUN: the read issued for linear address H_RES*V_RES-1 -> DRAIN.
  - DRAIN: FIFO empty and no read in flight -> IDLE.
- Counters:
  - Linear read address counter 0..H_RES*V_RES-1; increments on each issued read; no wrap within a frame.
  - Issue-side x/y counters travel with each request as sideband (sof/eol/eof flags).
  - eol is asserted when x=H_RES-1; eof is asserted on address H_RES*V_RES-1.
- Read issue:
  - o_bram_rd is combinational: state==RUN && (inflight + fifo_count - pop) < 2, where pop = o_pix_valid && i_pix_ready.
  - o_bram_rd_addr equals the counter value in the same cycle.
- Return path:
  - inflight is registered o_bram_rd.
  - When inflight=1, {i_bram_data, flags} are written to the FIFO at the next edge.
- Stream rules:
  - o_pix_valid = FIFO not empty.
  - Data and flags are held stable while valid && !ready.
  - Pop occurs on valid && ready; simultaneous push and pop is allowed.
- Latency: with i_frame_start in cycle 0:
  - cycle 1: o_bram_rd=1, addr 0
  - cycle 2: BRAM data valid
  - cycle 3: o_pix_valid=1 with sof=1
- Throughput: with ready held high, one pixel per clock; the full frame's last pixel appears in cycle 2+H_RES*V_RES.
- Never more than 2 pixels are buffered or in flight; FIFO overflow is impossible by the credit rule.
- i_frame_start in RUN or DRAIN (restart):
  - At the next edge, flush the FIFO, discard any in-flight return (inflight cleared), reset counters to 0, and go to RUN.
  - No pixel from the old frame appears after the restart edge.
- i_frame_start in IDLE coincident with i_rst: reset wins.
- o_busy = state != IDLE.

Optional Feature:
- Macro: FRAMEBUF_TEST_PATTERN_EN.
- Defined, with i_pattern_sel=1 at frame start (latched for the whole frame):
  - BRAM reads are suppressed (o_bram_rd=0).
  - The FIFO is fed with 8 vertical colour bars, each H_RES/8 pixels wide: white, yellow, cyan, green, magenta, red, blue, black (RGB444 0xFFF, 0xFF0, 0x0FF, 0x0F0, 0xF0F, 0xF00, 0x00F, 0x000).
  - Timing, flags and handshake are identical to a BRAM frame.
- Not defined: i_pattern_sel is ignored and no pattern logic is synthesised.

Decomposition:
- framebuf_pkg:
  - pixel_t typedef (logic [11:0]).
  - Default H_RES/V_RES constants.
  - Colour-bar constant array.
  - Sideband flag struct {sof, eol, eof}.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module framebuf_skid_fifo:
  - Depth 2, payload PIX_W+3.
  - Synchronous flush.
  - Push/pop same cycle.
  - Exposes count.

Test Plan:
- Reset, then frame_start in cycle 0 with ready=1 and BRAM preloaded with mem[a]=a[11:0] -> rd addr 0 in cycle 1, first valid in cycle 3 with data 0x000 and sof=1; 76800 pixels in order; eol on every 320th; eof on pixel 76799; o_busy drops after it.
- Random ready (50% duty) over a full frame -> pixel sequence identical to the ready=1 run, no gaps in address order, never more than 2 reads outstanding+buffered, data stable while stalled.
- Ready held 0 for 100 cycles after the first valid -> exactly 2 reads issued, o_pix_data held at 0x000; release -> pixels 1, 2, 3… follow contiguously.
- frame_start at pixel 1000 while stalled with FIFO full -> FIFO flushed, next valid pixel is addr 0 with sof=1, no stale pixels 1000/1001 delivered.
- i_rst asserted mid-frame -> all outputs 0 next cycle, state IDLE, no further o_bram_rd until a new frame_start.
- With FRAMEBUF_TEST_PATTERN_EN and pattern_sel=1 -> o_bram_rd never asserts; pixels x=0..39 = 0xFFF, x=40..79 = 0xFF0, …, x=280..319 = 0x000 on every line.
